// File: rtl/irq_ctrl.sv
// irq_ctrl: sticky-pending interrupt controller with mask, global enable and kernel-mode IRQ sequencing; define IRQ_PRIO_EN for priority CAUSE with read auto-clear
module irq_ctrl #(
  parameter int NSRC = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030,
  parameter int HOLDOFF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            kernel,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);
  typedef enum logic [1:0] {IDLE, REQ, SVC, HOLD} state_t;
  state_t state;
  logic [NSRC-1:0] src_d, pend, mask, rise, pm, w1c, auto_clr;
  logic gie, active, sel, unused_bits;
  logic [1:0] off;
  logic [3:0] cnt;
  logic [31:0] cause;
  assign sel = addr[31:4] == BASE_ADDR[31:4];
  assign off = addr[3:2];
  assign rise = src & ~src_d;
  assign pm = pend & mask;
  assign active = |pm & gie;
  assign w1c = (wr && sel && off == 2'd0) ? wdata[NSRC-1:0] : '0;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};
`ifdef IRQ_PRIO_EN
  logic [2:0] idx;
  // lowest-numbered pending masked source has priority
  always_comb begin
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (pm[i]) idx = 3'(i);
  end
  assign auto_clr = (rd && sel && off == 2'd3) ? pm & (~pm + NSRC'(1)) : '0;
  assign cause = {active, 28'd0, idx};
`else
  assign auto_clr = '0;
  assign cause = {active, 31'd0} | (32'(pm) << 8);
`endif
  assign rdata = (rd && sel) ? (off == 2'd0 ? 32'(pend) :
                                off == 2'd1 ? 32'(mask) :
                                off == 2'd2 ? {31'd0, gie} : cause) : '0;
  // edge capture, sticky pending bits (set beats clear) and writable registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      src_d <= '0;
      pend <= '0;
      mask <= '0;
      gie <= 1'b0;
    end else begin
      src_d <= src;
      pend <= (pend & ~(w1c | auto_clr)) | rise;
      if (wr && sel && off == 2'd1) mask <= wdata[NSRC-1:0];
      if (wr && sel && off == 2'd2) gie <= wdata[0];
    end
  // request sequencing against kernel mode; irq is registered and never set while kernel is sampled high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      irq <= 1'b0;
    end else begin
      irq <= state == REQ && !kernel && active;
      case (state)
        IDLE: if (active && !kernel) state <= REQ;
        REQ: state <= kernel ? SVC : !active ? IDLE : REQ;
        SVC:
          if (!kernel) begin
            state <= HOLDOFF > 0 ? HOLD : IDLE;
            cnt <= 4'(HOLDOFF - 1);
          end
        default:
          if (cnt == 4'd0) state <= IDLE;
          else cnt <= cnt - 4'd1;
      endcase
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven scoreboard bench for irq_ctrl
module tb_irq_ctrl;
  localparam logic [31:0] A_PEND = 32'h40000030;
  localparam logic [31:0] A_MASK = 32'h40000034;
  localparam logic [31:0] A_CTRL = 32'h40000038;
  localparam logic [31:0] A_CAUSE = 32'h4000003C;
  typedef struct {
    string name;
    logic [3:0] src;
    logic kernel, rd, wr;
    logic [31:0] addr, wdata;
    logic exp_irq;
    logic [31:0] exp_rdata;
  } vec_t;
  typedef struct {
    string name;
    logic exp_irq;
    logic [31:0] exp_rdata;
  } exp_t;
  logic clk, reset, kernel, rd, wr, irq;
  logic [3:0] src;
  logic [31:0] addr, wdata, rdata;
  int n_vec, n_err;
  exp_t sb[$];
  vec_t tbl[$], pre[$], post[$], prio[$];
  irq_ctrl #(.NSRC(4), .BASE_ADDR(32'h40000030), .HOLDOFF(2)) dut (
    .clk(clk), .reset(reset), .src(src), .kernel(kernel), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(string n, logic [3:0] s, logic k, logic r, logic w,
                              logic [31:0] a, logic [31:0] d, logic ei, logic [31:0] er);
    vec_t v;
    v.name = n; v.src = s; v.kernel = k; v.rd = r; v.wr = w;
    v.addr = a; v.wdata = d; v.exp_irq = ei; v.exp_rdata = er;
    return v;
  endfunction
  function automatic vec_t rdv(string n, logic k, logic [31:0] a, logic ei, logic [31:0] er);
    return mk(n, 4'h0, k, 1'b1, 1'b0, a, 32'h0, ei, er);
  endfunction
  function automatic vec_t wrv(string n, logic k, logic [31:0] a, logic [31:0] d, logic ei);
    return mk(n, 4'h0, k, 1'b0, 1'b1, a, d, ei, 32'h0);
  endfunction
  function automatic vec_t idle(string n, logic k, logic ei);
    return mk(n, 4'h0, k, 1'b0, 1'b0, A_PEND, 32'h0, ei, 32'h0);
  endfunction
  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    src = v.src; kernel = v.kernel; rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    sb.push_back('{v.name, v.exp_irq, v.exp_rdata});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (irq !== e.exp_irq || rdata !== e.exp_rdata) begin
      n_err++;
      $display("FAIL %s: irq=%0b rdata=%h, expected irq=%0b rdata=%h", e.name, irq, rdata, e.exp_irq, e.exp_rdata);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl.push_back(rdv("rst_pend", 0, A_PEND, 0, 0));
    tbl.push_back(rdv("rst_mask", 0, A_MASK, 0, 0));
    tbl.push_back(rdv("rst_ctrl", 0, A_CTRL, 0, 0));
    tbl.push_back(rdv("rst_cause", 0, A_CAUSE, 0, 0));
    tbl.push_back(wrv("mask2", 0, A_MASK, 32'h2, 0));
    tbl.push_back(wrv("gie1", 0, A_CTRL, 32'h1, 0));
    tbl.push_back(mk("src1_rise", 4'h2, 0, 1, 0, A_PEND, 0, 0, 0));
    tbl.push_back(mk("pend_set", 4'h2, 0, 1, 0, A_PEND, 0, 0, 32'h2));
`ifdef IRQ_PRIO_EN
    tbl.push_back(rdv("mask_rb", 0, A_MASK, 0, 32'h2));
`else
    tbl.push_back(rdv("cause_np", 0, A_CAUSE, 0, 32'h80000200));
`endif
    tbl.push_back(rdv("irq_lat3", 0, A_CTRL, 1, 32'h1));
    tbl.push_back(rdv("req_kern", 1, A_PEND, 1, 32'h2));
    tbl.push_back(mk("rise_w1c", 4'h2, 1, 0, 1, A_PEND, 32'h2, 0, 0));
    tbl.push_back(rdv("set_wins", 1, A_PEND, 0, 32'h2));
    tbl.push_back(rdv("svc_exit", 0, A_PEND, 0, 32'h2));
    tbl.push_back(idle("hold_a", 0, 0));
    tbl.push_back(idle("hold_b", 0, 0));
    tbl.push_back(idle("hold_idle", 0, 0));
    tbl.push_back(idle("rereq", 0, 0));
    tbl.push_back(wrv("reirq_mask0", 0, A_MASK, 32'h0, 1));
    tbl.push_back(idle("req_drop", 0, 1));
    tbl.push_back(wrv("drop_clr", 0, A_PEND, 32'hF, 0));
    tbl.push_back(rdv("pend_clr", 0, A_PEND, 0, 0));
    tbl.push_back(wrv("gie_off", 0, A_CTRL, 32'h0, 0));
    tbl.push_back(wrv("mask_all", 0, A_MASK, 32'hF, 0));
    tbl.push_back(mk("src0_rise", 4'h1, 0, 0, 0, A_PEND, 0, 0, 0));
    tbl.push_back(mk("pend0", 4'h1, 0, 1, 0, A_PEND, 0, 0, 32'h1));
`ifdef IRQ_PRIO_EN
    tbl.push_back(rdv("mask_f", 0, A_MASK, 0, 32'hF));
`else
    tbl.push_back(rdv("cause_off", 0, A_CAUSE, 0, 32'h100));
`endif
    tbl.push_back(wrv("gie_on", 0, A_CTRL, 32'h1, 0));
    tbl.push_back(rdv("ctrl_rb", 0, A_CTRL, 0, 32'h1));
    tbl.push_back(idle("gie_req", 0, 0));
    tbl.push_back(wrv("gie_irq", 0, A_PEND, 32'h1, 1));
    tbl.push_back(idle("clr_req", 0, 1));
    tbl.push_back(idle("clr_idle", 0, 0));
    tbl.push_back(wrv("miss_wr", 0, 32'h50000034, 32'h0, 0));
    tbl.push_back(rdv("miss_mask", 0, A_MASK, 0, 32'hF));
    tbl.push_back(wrv("cause_wr", 0, A_CAUSE, 32'hFFFFFFFF, 0));
    tbl.push_back(rdv("cause_ro", 0, A_CAUSE, 0, 32'h0));
    tbl.push_back(rdv("miss_rd", 0, 32'h40000134, 0, 32'h0));
    tbl.push_back(wrv("mask_hi", 0, A_MASK, 32'hFFFFFFF5, 0));
    tbl.push_back(rdv("mask_5", 0, A_MASK, 0, 32'h5));
    pre.push_back(mk("d_rise", 4'h4, 0, 0, 0, A_PEND, 0, 0, 0));
    pre.push_back(idle("d_latch", 0, 0));
    pre.push_back(idle("d_req", 0, 0));
    pre.push_back(idle("d_irq", 0, 1));
    post.push_back(rdv("ar_pend", 0, A_PEND, 0, 0));
    post.push_back(rdv("ar_mask", 0, A_MASK, 0, 0));
    post.push_back(rdv("ar_ctrl", 0, A_CTRL, 0, 0));
    prio.push_back(wrv("p_mask", 1, A_MASK, 32'hF, 0));
    prio.push_back(wrv("p_gie", 1, A_CTRL, 32'h1, 0));
    prio.push_back(mk("p_rise", 4'hA, 1, 0, 0, A_PEND, 0, 0, 0));
    prio.push_back(mk("p_cause1", 4'hA, 1, 1, 0, A_CAUSE, 0, 0, 32'h80000001));
    prio.push_back(rdv("p_pend8", 1, A_PEND, 0, 32'h8));
    prio.push_back(rdv("p_cause3", 1, A_CAUSE, 0, 32'h80000003));
    prio.push_back(rdv("p_pend0", 1, A_PEND, 0, 32'h0));
    prio.push_back(mk("p_rise1", 4'h2, 1, 0, 0, A_PEND, 0, 0, 0));
    prio.push_back(rdv("p_pend2", 1, A_PEND, 0, 32'h2));
    prio.push_back(mk("p_setwin", 4'h2, 1, 1, 0, A_CAUSE, 0, 0, 32'h80000001));
    prio.push_back(rdv("p_kept", 1, A_PEND, 0, 32'h2));
    n_vec = 0; n_err = 0;
    reset = 1'b1; src = '0; kernel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    foreach (tbl[i]) apply(tbl[i]);
    foreach (pre[i]) apply(pre[i]);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: irq=%0b, expected 0", irq);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (post[i]) apply(post[i]);
`ifdef IRQ_PRIO_EN
    foreach (prio[i]) apply(prio[i]);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
